// File: rtl/sort4_pkg.sv
// Shared types and constants for the four-word streaming sorter.
package sort4_pkg;

    localparam int W_DEFAULT   = 8;
    localparam int BATCH       = 4;
    localparam int SORT_STAGES = 3;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sort4_stream_cmp_swap.sv
// Combinational compare-exchange: lo goes to the lower index, hi to the higher.
// Define SORT4_STREAM_DESC_EN to put the larger word at the lower index.
module cmp_swap
    import sort4_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic swap;

    // Equal words never swap, so ties pass through in their original slots.
`ifdef SORT4_STREAM_DESC_EN
    assign swap = (b > a);
`else
    assign swap = (a > b);
`endif

    assign lo = swap ? b : a;
    assign hi = swap ? a : b;

endmodule

// File: rtl/sort4_stream.sv
// Collects four words, sorts them through a registered 3-stage network, then streams them out.
// Build option: define SORT4_STREAM_DESC_EN (inside cmp_swap) for descending order.
module sort4_stream
    import sort4_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    typedef logic [BATCH-1:0][W-1:0] vec_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    vec_t       slot_q, slot_d;
    vec_t       s1_q, s1_d;
    vec_t       s2_q, s2_d;
    vec_t       s3_q, s3_d;
    vec_t       net1, net2, net3;

    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         out_last_q, out_last_d;
    logic         busy_q, busy_d;

    cmp_swap #(.W(W)) u_s1_01 (.a(slot_q[0]), .b(slot_q[1]), .lo(net1[0]), .hi(net1[1]));
    cmp_swap #(.W(W)) u_s1_23 (.a(slot_q[2]), .b(slot_q[3]), .lo(net1[2]), .hi(net1[3]));
    cmp_swap #(.W(W)) u_s2_02 (.a(s1_q[0]),   .b(s1_q[2]),   .lo(net2[0]), .hi(net2[2]));
    cmp_swap #(.W(W)) u_s2_13 (.a(s1_q[1]),   .b(s1_q[3]),   .lo(net2[1]), .hi(net2[3]));
    cmp_swap #(.W(W)) u_s3_12 (.a(s2_q[1]),   .b(s2_q[2]),   .lo(net3[1]), .hi(net3[2]));

    assign net3[0] = s2_q[0];
    assign net3[3] = s2_q[3];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;

        case (state_q)
            FILL: begin
                if (in_valid && in_ready_q) begin
                    slot_d[cnt_q] = in_data;
                    cnt_d         = cnt_q + 2'd1;
                    if (cnt_q == 2'(BATCH - 1)) begin
                        state_d = SORT;
                    end
                end
            end
            // Every stage reloads each SORT cycle; by the last cycle the data has rippled through all three.
            SORT: begin
                s1_d = net1;
                s2_d = net2;
                s3_d = net3;
                if (cnt_q == 2'(SORT_STAGES - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'(BATCH - 1)) begin
                        state_d = FILL;
                    end
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = 2'd0;
            end
        endcase

        // Outputs are decoded from next state so they land in flops alongside the state they describe.
        in_ready_d  = (state_d == FILL);
        out_valid_d = (state_d == DRAIN);
        busy_d      = (state_d != FILL);
        out_last_d  = out_valid_d && (cnt_d == 2'(BATCH - 1));
        out_data_d  = out_valid_d ? s3_d[cnt_d] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= 2'd0;
            slot_q      <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule
